k_fetch: RTL
============

# k_fetch

Sequencer feeding the SHA-256 round-constant collector. On `start` it reads the K_LENGTH round constants from the K-constant memory with a fixed, pipelined read latency. It presents each returned word with its index on `k_address`/`k_data`/`k_valid`, then raises `address_read_complete` so the collector can flag its K vector complete. It sits between the constant memory and the K-vector assembly stage, and is the read side of that word interface.

## Interface
- K_LENGTH, 64, number of 32-bit constants fetched per run
- MEM_LATENCY, 1, cycles from address issue to `mem_read_data` valid (legal 1..4)
- MEM_ADDR_WIDTH, 16, width of the memory address bus
- BASE_ADDRESS, 0, memory address of constant 0

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run qualifier; low aborts and clears the block
- start  input  1  one-cycle request to begin a fetch run
- mem_read_enable  output  1  memory read strobe
- mem_read_address  output  MEM_ADDR_WIDTH  word address to memory
- mem_read_data  input  32  memory read data, valid MEM_LATENCY cycles after strobe
- k_address  output  clog2(K_LENGTH)  index of the word on `k_data`
- k_data  output  32  constant word
- k_valid  output  1  `k_address`/`k_data` valid this cycle
- address_read_complete  output  1  all K_LENGTH words delivered; held high
- busy  output  1  high in FETCH or DRAIN

## Operation
- States: IDLE, FETCH, DRAIN, DONE. All outputs are registered.
- Reset (reset=0): state IDLE. Every output is 0, counters are 0, and the latency pipe is cleared.
- IDLE: on `start`=1 with `enable`=1, go to FETCH. The issue counter is 0 and the return counter is 0.
- FETCH:
  - Each cycle: `mem_read_enable`=1, `mem_read_address`=BASE_ADDRESS+issue_count, and issue_count increments.
  - After issuing index K_LENGTH-1, go to DRAIN.
  - Issue is back-to-back with no gaps.
- Latency pipe: a MEM_LATENCY-deep shift register of valid bits marks in-flight reads. When a marked read returns, capture `mem_read_data` into `k_data`, set `k_address`=return_count, pulse `k_valid`, and increment return_count.
- DRAIN: no new issues and `mem_read_enable`=0. When the word at index K_LENGTH-1 has been presented, go to DONE.
- DONE:
  - `address_read_complete`=1 and `k_valid`=0.
  - `k_address`/`k_data` hold the last word.
  - Stay in DONE while `enable`=1. `start` in DONE restarts a run: go to FETCH and clear `address_read_complete`.
- `enable`=0 in any state:
  - Next cycle the state is IDLE, and `mem_read_enable`, `k_valid`, `address_read_complete` and `busy` are 0.
  - Counters are cleared and in-flight returns are discarded.
- `start` in FETCH/DRAIN is ignored.
- `start` and `enable` falling in the same cycle: abort wins.
- Widths:
  - The issue and return counters are clog2(K_LENGTH)+1 bits, so they reach K_LENGTH without wrapping.
  - `k_address` is the low clog2(K_LENGTH) bits.
  - `mem_read_address` addition wraps modulo 2^MEM_ADDR_WIDTH.

## Timing
- `start` sampled high at edge 0 puts read i on the memory bus in cycle 1+i (i = 0..K_LENGTH-1).
- Data for read i is valid on `mem_read_data` in cycle 1+i+MEM_LATENCY. The block presents it with `k_valid`=1 in cycle 2+i+MEM_LATENCY.
- `k_valid` is high for exactly K_LENGTH consecutive cycles.
- `address_read_complete` rises in cycle 2+K_LENGTH+MEM_LATENCY, the cycle after the last `k_valid`.
- Total latency from `start` to complete is K_LENGTH+MEM_LATENCY+2 cycles. With the defaults this is 67.
- `busy` is high from cycle 1 through the last `k_valid` cycle.
- Asynchronous reset clears outputs immediately, without waiting for a clock edge. Reset release is sampled at the next edge.

## Test plan
- Defaults, memory model returns data = 32'h4280_0000 + addr, `start` at cycle 0:
  - 64 consecutive `k_valid` in cycles 3..66, with `k_address` 0..63 and matching data.
  - `address_read_complete`=1 from cycle 67.
- MEM_LATENCY=3:
  - First `k_valid` at cycle 5, last at cycle 68.
  - Complete at cycle 69.
  - `mem_read_enable` high in cycles 1..64 only.
- Abort: deassert `enable` at cycle 20:
  - Cycle 21: IDLE, all outputs 0.
  - Returns still in flight produce no `k_valid`.
  - A new `start` at cycle 25 restarts from `k_address`=0.
- Restart from DONE: after complete, pulse `start` with `enable`=1:
  - `address_read_complete` drops the next cycle.
  - Full 64-word sequence repeats.
- `start` pulses during FETCH at cycles 10 and 30 are ignored: exactly 64 words are delivered and the timing is unchanged.
- Assert reset (0) mid-DRAIN between clock edges:
  - All outputs read 0 before the next edge.
  - After release the block stays IDLE until `start`.

Source files
------------

// File: rtl/k_fetch_if.sv
// Word interface between k_fetch, the K-constant memory and the K-vector collector.
// k_valid is a one-cycle qualifier for k_address/k_data with no ready: the collector must accept every word.
interface k_fetch_if #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int K_LENGTH       = 64
);
  localparam int AW = $clog2(K_LENGTH);

  logic                      enable;
  logic                      start;
  logic                      mem_read_enable;
  logic [MEM_ADDR_WIDTH-1:0] mem_read_address;
  logic [31:0]               mem_read_data;
  logic [AW-1:0]             k_address;
  logic [31:0]               k_data;
  logic                      k_valid;
  logic                      address_read_complete;
  logic                      busy;

  modport master (
    input  enable, start, mem_read_data,
    output mem_read_enable, mem_read_address, k_address, k_data, k_valid,
           address_read_complete, busy
  );

  modport slave (
    output enable, start, mem_read_data,
    input  mem_read_enable, mem_read_address, k_address, k_data, k_valid,
           address_read_complete, busy
  );
endinterface

// File: rtl/k_fetch.sv
// Reads K_LENGTH SHA-256 round constants from a fixed-latency memory and
// presents them in order with their index; all outputs are registered.
module k_fetch #(
  parameter int K_LENGTH       = 64,
  parameter int MEM_LATENCY    = 1,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int BASE_ADDRESS   = 0
) (
  input  logic        clock,
  input  logic        reset,
  k_fetch_if.master   bus,
  output logic [1:0]  dbg_state
);
  localparam int AW = $clog2(K_LENGTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]             K_END = CW'(K_LENGTH);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE  = MEM_ADDR_WIDTH'(BASE_ADDRESS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             issue_q, issue_d;
  logic [CW-1:0]             ret_q, ret_d;
  logic [MEM_LATENCY-1:0]    pipe_q, pipe_d;
  logic                      mre_q, mre_d;
  logic [MEM_ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                      kv_q, kv_d;
  logic [AW-1:0]             ka_q, ka_d;
  logic [31:0]               kd_q, kd_d;
  logic                      cpl_q, cpl_d;
  logic                      busy_q, busy_d;
  logic                      ret_hit;

  // The oldest pipe bit lines up with the cycle the memory drives its data.
  assign ret_hit = pipe_q[MEM_LATENCY-1];

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    ret_d   = ret_q + CW'(ret_hit);
    pipe_d  = MEM_LATENCY'({pipe_q, mre_q});
    mre_d   = 1'b0;
    maddr_d = maddr_q;
    kv_d    = ret_hit;
    ka_d    = ret_hit ? ret_q[AW-1:0] : ka_q;
    kd_d    = ret_hit ? bus.mem_read_data : kd_q;
    cpl_d   = cpl_q;

    case (state_q)
      IDLE, DONE: begin
        // Index 0 is issued on the entry edge so issue runs back-to-back.
        if (bus.start) begin
          state_d = FETCH;
          mre_d   = 1'b1;
          maddr_d = BASE;
          issue_d = CW'(1);
          ret_d   = '0;
          cpl_d   = 1'b0;
        end
      end
      FETCH: begin
        if (issue_q == K_END) begin
          state_d = DRAIN;
        end else begin
          mre_d   = 1'b1;
          maddr_d = BASE + MEM_ADDR_WIDTH'(issue_q);
          issue_d = issue_q + CW'(1);
        end
      end
      DRAIN: begin
        if (ret_q == K_END) begin
          state_d = DONE;
          cpl_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.enable) begin
      state_d = IDLE;
      issue_d = '0;
      ret_d   = '0;
      pipe_d  = '0;
      mre_d   = 1'b0;
      maddr_d = '0;
      kv_d    = 1'b0;
      ka_d    = '0;
      kd_d    = '0;
      cpl_d   = 1'b0;
    end

    busy_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      issue_q <= '0;
      ret_q   <= '0;
      pipe_q  <= '0;
      mre_q   <= 1'b0;
      maddr_q <= '0;
      kv_q    <= 1'b0;
      ka_q    <= '0;
      kd_q    <= '0;
      cpl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      pipe_q  <= pipe_d;
      mre_q   <= mre_d;
      maddr_q <= maddr_d;
      kv_q    <= kv_d;
      ka_q    <= ka_d;
      kd_q    <= kd_d;
      cpl_q   <= cpl_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_read_enable       = mre_q;
  assign bus.mem_read_address      = maddr_q;
  assign bus.k_valid               = kv_q;
  assign bus.k_address             = ka_q;
  assign bus.k_data                = kd_q;
  assign bus.address_read_complete = cpl_q;
  assign bus.busy                  = busy_q;
  assign dbg_state                 = state_q;
endmodule
